// File: rtl/axis_video_pkg.sv
// Shared types, pattern codes and pixel packing for the AXI4-Stream video frame source.
package axis_video_pkg;

   localparam int unsigned PIX_W  = 32;
   localparam int unsigned COMP_W = 10;
   localparam int unsigned PAT_W  = 2;
   localparam int unsigned D_W    = 4;
   localparam int unsigned BAR_W  = 3;
   localparam int unsigned FC_W   = 16;

   localparam logic [PAT_W-1:0] PAT_INCR  = 2'd0;
   localparam logic [PAT_W-1:0] PAT_BARS  = 2'd1;
   localparam logic [PAT_W-1:0] PAT_RAMP  = 2'd2;
   localparam logic [PAT_W-1:0] PAT_SOLID = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_HBLANK = 2'd2,
      ST_VBLANK = 2'd3
   } state_t;

   typedef struct packed {
      logic [COMP_W-1:0] c2;
      logic [COMP_W-1:0] c1;
      logic [COMP_W-1:0] c0;
   } pix_t;

   function automatic logic [PIX_W-1:0] pack_pix(input logic [COMP_W-1:0] c2,
                                                 input logic [COMP_W-1:0] c1,
                                                 input logic [COMP_W-1:0] c0);
      return {2'b00, c2, c1, c0};
   endfunction

endpackage

// File: rtl/axis_video_if.sv
// AXI4-Stream video beat bundle: master drives data/valid/user/last, slave drives ready.
interface axis_video_if;
   import axis_video_pkg::*;

   logic [PIX_W-1:0] tdata;
   logic             tvalid;
   logic             tready;
   logic             tuser;
   logic             tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/axis_pattern_gen.sv
// Combinational pixel generator: components for one beat from pattern, ramp, bar index, d and solid.
module axis_pattern_gen
   import axis_video_pkg::*;
(
   input  logic [PAT_W-1:0]  pat,
   input  logic [COMP_W-1:0] ramp,
   input  logic [BAR_W-1:0]  bar_idx,
   input  logic [D_W-1:0]    d,
   input  logic [COMP_W-1:0] solid,
   output pix_t              pix_c
);

   always_comb begin
      pix_c = '0;
      case (pat)
         PAT_INCR: begin
            pix_c.c0 = {d, 6'b000000};
            pix_c.c1 = {d, 6'b000000};
            pix_c.c2 = {d, 6'b000000};
         end
         PAT_BARS: begin
            pix_c.c0 = {COMP_W{bar_idx[0]}};
            pix_c.c1 = {COMP_W{bar_idx[1]}};
            pix_c.c2 = {COMP_W{bar_idx[2]}};
         end
         PAT_RAMP: begin
            pix_c.c0 = ramp;
            pix_c.c1 = ramp;
            pix_c.c2 = ramp;
         end
         default: begin
            pix_c.c0 = solid;
            pix_c.c1 = solid;
            pix_c.c2 = solid;
         end
      endcase
   end

endmodule

// File: rtl/axis_video_frame_src.sv
// AXI4-Stream video frame source: line/frame sequencing with blanking, pattern latched per frame.
module axis_video_frame_src
   import axis_video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned H_BLANK  = 1750,
   parameter int unsigned V_BLANK  = 64,
   parameter int unsigned CNT_W    = 12
)(
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic [PAT_W-1:0]  pattern_sel,
   input  logic [COMP_W-1:0] solid_val,
   axis_video_if.master      m_axis_video,
   output logic [FC_W-1:0]   frame_cnt,
   output logic              busy
);

   localparam int unsigned BLK_W = $clog2(H_BLANK + V_BLANK + 1);
   localparam int unsigned ACC_W = CNT_W + 4;
   localparam logic [CNT_W-1:0] LAST_X = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(V_ACTIVE - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  x, y;
   logic [BAR_W-1:0]  bar_idx;
   logic [ACC_W-1:0]  bar_acc;
   logic [BLK_W-1:0]  blank_cnt;
   logic [D_W-1:0]    d;
   logic [PAT_W-1:0]  frame_pat;
   logic [COMP_W-1:0] frame_solid;

   logic              hs_c, sof_c, line_start_c, advance_c, eol_c, frame_end_c, load_c;
   logic [CNT_W-1:0]  px_c;
   logic [BAR_W-1:0]  pbar_c;
   logic [ACC_W-1:0]  pacc_c;
   logic [D_W-1:0]    pd_c;
   logic [PAT_W-1:0]  ppat_c;
   logic [COMP_W-1:0] psolid_c;
   pix_t              pix_c;

   assign hs_c = m_axis_video.tvalid & m_axis_video.tready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         ST_IDLE:   if (enable) state_n = ST_ACTIVE;
         ST_ACTIVE: if (hs_c && m_axis_video.tlast)
                       state_n = (y == LAST_Y) ? ST_VBLANK : ST_HBLANK;
         ST_HBLANK: if (blank_cnt == '0) state_n = ST_ACTIVE;
         ST_VBLANK: if (blank_cnt == '0) state_n = enable ? ST_ACTIVE : ST_IDLE;
         default:   state_n = ST_IDLE;
      endcase
   end

   always_comb begin
      sof_c        = 1'b0;
      line_start_c = 1'b0;
      advance_c    = 1'b0;
      eol_c        = 1'b0;
      frame_end_c  = 1'b0;
      case (state)
         ST_IDLE:   sof_c = enable;
         ST_ACTIVE: begin
            if (hs_c) begin
               if (m_axis_video.tlast) begin
                  eol_c       = 1'b1;
                  frame_end_c = (y == LAST_Y);
               end else begin
                  advance_c = 1'b1;
               end
            end
         end
         ST_HBLANK: line_start_c = (blank_cnt == '0);
         ST_VBLANK: sof_c = (blank_cnt == '0) && enable;
         default:   ;
      endcase
      load_c = sof_c | line_start_c | advance_c;
   end

   // Values for the beat about to be presented; the bar counter replaces x*8/H_ACTIVE.
   always_comb begin
      px_c   = x;
      pbar_c = bar_idx;
      pacc_c = bar_acc;
      if (advance_c) begin
         px_c   = x + CNT_W'(1);
         pacc_c = bar_acc + ACC_W'(8);
         if (pacc_c >= ACC_W'(H_ACTIVE)) begin
            pacc_c = pacc_c - ACC_W'(H_ACTIVE);
            pbar_c = bar_idx + BAR_W'(1);
         end
      end
      pd_c     = hs_c ? d + D_W'(1) : d;
      ppat_c   = sof_c ? pattern_sel : frame_pat;
      psolid_c = sof_c ? solid_val : frame_solid;
   end

   axis_pattern_gen u_pattern_gen (
      .pat     (ppat_c),
      .ramp    (COMP_W'(px_c)),
      .bar_idx (pbar_c),
      .d       (pd_c),
      .solid   (psolid_c),
      .pix_c   (pix_c)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         x           <= '0;
         y           <= '0;
         bar_idx     <= '0;
         bar_acc     <= '0;
         blank_cnt   <= '0;
         d           <= '0;
         frame_pat   <= '0;
         frame_solid <= '0;
         frame_cnt   <= '0;
         busy        <= 1'b0;
      end else begin
         if (hs_c) d <= pd_c;
         if (sof_c) begin
            frame_pat   <= pattern_sel;
            frame_solid <= solid_val;
         end
         if (advance_c) begin
            x       <= px_c;
            bar_idx <= pbar_c;
            bar_acc <= pacc_c;
         end else if (eol_c) begin
            x       <= '0;
            bar_idx <= '0;
            bar_acc <= '0;
            y       <= frame_end_c ? '0 : y + CNT_W'(1);
         end
         if (eol_c)
            blank_cnt <= frame_end_c ? BLK_W'(H_BLANK + V_BLANK - 1) : BLK_W'(H_BLANK - 1);
         else if ((state == ST_HBLANK || state == ST_VBLANK) && blank_cnt != '0)
            blank_cnt <= blank_cnt - BLK_W'(1);
         if (frame_end_c) frame_cnt <= frame_cnt + FC_W'(1);
         busy <= (state_n != ST_IDLE);
      end
   end

   // Output beat register: held across stalls, reloaded only when a new beat is presented.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_axis_video.tvalid <= 1'b0;
         m_axis_video.tdata  <= '0;
         m_axis_video.tuser  <= 1'b0;
         m_axis_video.tlast  <= 1'b0;
      end else if (load_c) begin
         m_axis_video.tvalid <= 1'b1;
         m_axis_video.tdata  <= pack_pix(pix_c.c2, pix_c.c1, pix_c.c0);
         m_axis_video.tuser  <= (px_c == '0) && (y == '0);
         m_axis_video.tlast  <= (px_c == LAST_X);
      end else if (eol_c) begin
         m_axis_video.tvalid <= 1'b0;
         m_axis_video.tuser  <= 1'b0;
         m_axis_video.tlast  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axis_video_frame_src.sv
// Randomized bench for axis_video_frame_src against a frame-level reference model (8x4 frames).
module tb_axis_video_frame_src;
   import axis_video_pkg::*;

   localparam int unsigned H = 8, V = 4, HB = 3, VB = 2;
   localparam int unsigned BEATS = H * V;
   localparam int BOUND = 4000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enable = 1'b0;
   logic [1:0]  pattern_sel = 2'd0;
   logic [9:0]  solid_val = 10'd0;
   logic [15:0] frame_cnt;
   logic        busy;
   logic        rdy_rand = 1'b0;

   axis_video_if vif();

   axis_video_frame_src #(.H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .V_BLANK(VB), .CNT_W(12)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .enable       (enable),
      .pattern_sel  (pattern_sel),
      .solid_val    (solid_val),
      .m_axis_video (vif),
      .frame_cnt    (frame_cnt),
      .busy         (busy)
   );

   initial forever #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [33:0] obs[$];
   logic [33:0] exp_q[$];
   int          m_d = 0;
   logic [15:0] m_frames = 16'd0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
      n_tests++;
      if (got !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
      end
   endtask

   function automatic logic [31:0] model_pix(input int pat, input logic [9:0] sol, input int x, input int dv);
      logic [9:0] c0, c1, c2;
      int bar;
      case (pat)
         0: begin c0 = 10'((dv % 16) * 64); c1 = c0; c2 = c0; end
         1: begin
            bar = x * 8 / H;
            c0 = (bar % 2 == 1) ? 10'h3FF : 10'h000;
            c1 = ((bar / 2) % 2 == 1) ? 10'h3FF : 10'h000;
            c2 = ((bar / 4) % 2 == 1) ? 10'h3FF : 10'h000;
         end
         2: begin c0 = 10'(x % 1024); c1 = c0; c2 = c0; end
         default: begin c0 = sol; c1 = sol; c2 = sol; end
      endcase
      return {2'b00, c2, c1, c0};
   endfunction

   initial begin
      vif.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         vif.tready = rdy_rand ? ($urandom_range(0, 9) >= 3) : 1'b1;
      end
   end

   // Monitor: collects accepted beats, checks stall stability and blanking lengths.
   initial begin
      logic [33:0] cur, p_beat;
      bit p_stall, after_eol, p_busy;
      int idle_run;
      p_stall = 0; after_eol = 0; p_busy = 0; idle_run = 0; p_beat = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            p_stall = 0; after_eol = 0; p_busy = 0; idle_run = 0;
         end else begin
            cur = {vif.tuser, vif.tlast, vif.tdata};
            if (p_stall) begin
               chk("stall_valid", 64'(vif.tvalid), 64'(1));
               chk("stall_hold", 64'(cur), 64'(p_beat));
            end
            if (p_busy && !busy && after_eol) chk("vblank_len", 64'(idle_run), 64'(HB + VB));
            if (vif.tvalid) begin
               if (after_eol) chk("blank_len", 64'(idle_run), vif.tuser ? 64'(HB + VB) : 64'(HB));
               after_eol = 0;
               if (vif.tready) begin
                  obs.push_back(cur);
                  if (vif.tlast) begin after_eol = 1; idle_run = 0; end
               end
            end else if (after_eol) begin
               idle_run++;
            end
            if (!busy) after_eol = 0;
            p_stall = vif.tvalid && !vif.tready;
            p_beat  = cur;
            p_busy  = busy;
         end
      end
   end

   task automatic run_frames(input int n, input int pat0, input logic [9:0] sol0,
                             input int pat1, input logic [9:0] sol1,
                             input int switch_at, input int drop_at);
      int p, cyc;
      logic [9:0] s;
      obs.delete();
      exp_q.delete();
      for (int f = 0; f < n; f++) begin
         p = (f == 0) ? pat0 : pat1;
         s = (f == 0) ? sol0 : sol1;
         for (int yy = 0; yy < int'(V); yy++)
            for (int xx = 0; xx < int'(H); xx++) begin
               exp_q.push_back({(xx == 0 && yy == 0), (xx == int'(H) - 1), model_pix(p, s, xx, m_d)});
               m_d = (m_d + 1) % 16;
            end
         m_frames = m_frames + 16'd1;
      end
      pattern_sel = 2'(pat0);
      solid_val   = sol0;
      enable      = 1'b1;
      cyc = 0;
      while (obs.size() < n * int'(BEATS) && cyc < BOUND) begin
         @(posedge clk);
         #1;
         cyc++;
         if (obs.size() >= switch_at) begin pattern_sel = 2'(pat1); solid_val = sol1; end
         if (obs.size() >= drop_at) enable = 1'b0;
      end
      enable = 1'b0;
      if (cyc >= BOUND) chk("beats_timeout", 64'(obs.size()), 64'(n * int'(BEATS)));
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (busy && cyc < 200);
      chk("idle_reached", 64'(busy), 64'(0));
      repeat (20) @(negedge clk);
      chk("no_extra_beats", 64'(obs.size()), 64'(n * int'(BEATS)));
      chk("tvalid_idle", 64'(vif.tvalid), 64'(0));
      for (int i = 0; i < exp_q.size(); i++)
         chk($sformatf("beat%0d", i), (i < obs.size()) ? 64'(obs[i]) : 64'(0), 64'(exp_q[i]));
      chk("frame_cnt", 64'(frame_cnt), 64'(m_frames));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got stuck expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cyc;
      #12;
      chk("rst_tvalid", 64'(vif.tvalid), 64'(0));
      chk("rst_tdata", 64'(vif.tdata), 64'(0));
      chk("rst_tuser", 64'(vif.tuser), 64'(0));
      chk("rst_tlast", 64'(vif.tlast), 64'(0));
      chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      @(negedge clk);
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // incrementing pattern, continuous ready, two back-to-back frames
      run_frames(2, 0, 10'd0, 0, 10'd0, 1 << 20, int'(BEATS) + 1);

      // random backpressure
      rdy_rand = 1'b1;
      run_frames(2, 0, 10'd0, 0, 10'd0, 1 << 20, int'(BEATS) + 1);

      // colour bars
      run_frames(1, 1, 10'd0, 1, 10'd0, 1 << 20, 1);

      // solid frame with mid-frame switch to ramp; switch applies from the next frame
      run_frames(2, 3, 10'h155, 2, 10'($urandom_range(0, 1023)), 5, int'(BEATS) + 1);

      // enable dropped during line 2 of a random pattern
      run_frames(1, int'($urandom_range(0, 3)), 10'($urandom_range(0, 1023)), 0, 10'd0, 1 << 20, 2 * int'(H) + 2);

      // asynchronous reset in the middle of a line
      rdy_rand = 1'b0;
      obs.delete();
      pattern_sel = 2'd0;
      enable = 1'b1;
      cyc = 0;
      while (obs.size() < 11 && cyc < BOUND) begin @(negedge clk); cyc++; end
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_tvalid", 64'(vif.tvalid), 64'(0));
      chk("arst_tuser", 64'(vif.tuser), 64'(0));
      chk("arst_tlast", 64'(vif.tlast), 64'(0));
      chk("arst_frame_cnt", 64'(frame_cnt), 64'(0));
      enable = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      m_d = 0;
      m_frames = 16'd0;
      @(negedge clk);
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'(0));
      run_frames(1, 0, 10'd0, 0, 10'd0, 1 << 20, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
